// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selector and load-use stall generator with its own shadow pipeline of
// producer info. Define FWD_HAZARD_STATS_EN to add stall/forward/flush event counters.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      ex_valid
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]               stat_stall,
  output logic [31:0]               stat_fwd,
  output logic [31:0]               stat_flush
`endif
);

  // Slot 0 is EX, slot k is the k-th stage after EX.
  logic [FWD_DEPTH:0]                 valid_q, valid_d;
  logic [FWD_DEPTH:0]                 reg_write_q, reg_write_d;
  logic [FWD_DEPTH:0]                 mem_read_q, mem_read_d;
  logic [FWD_DEPTH:0][REG_AW-1:0]     rd_q, rd_d;
  logic [NUM_SRC-1:0][REG_AW-1:0]     ex_rs_q, ex_rs_d;
  logic [NUM_SRC-1:0]                 ex_rs_used_q, ex_rs_used_d;
  logic                               load_valid;
  logic                               load_fwd_err;

  always_comb begin
    stall = 1'b0;
    for (int unsigned j = 0; j + 1 < LOAD_STAGE; j++) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (valid_q[j] && reg_write_q[j] && mem_read_q[j] && id_rs_used[i] &&
            (id_rs[i*REG_AW +: REG_AW] != '0) &&
            (rd_q[j] == id_rs[i*REG_AW +: REG_AW])) begin
          stall = 1'b1;
        end
      end
    end
    if (!id_valid || flush) stall = 1'b0;
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (valid_q[0] && ex_rs_used_q[i] && (ex_rs_q[i] != '0)) begin
        for (int k = int'(FWD_DEPTH); k >= 1; k--) begin
          if (valid_q[k] && reg_write_q[k] && (rd_q[k] == ex_rs_q[i])) begin
            fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
          end
        end
      end
    end
  end

  assign ex_valid   = valid_q[0];
  assign load_valid = id_valid && !stall && !flush;

  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    rd_d         = rd_q;
    ex_rs_d      = ex_rs_q;
    ex_rs_used_d = ex_rs_used_q;
    if (en) begin
      for (int unsigned j = FWD_DEPTH; j >= 1; j--) begin
        valid_d[j]     = valid_q[j-1];
        reg_write_d[j] = reg_write_q[j-1];
        mem_read_d[j]  = mem_read_q[j-1];
        rd_d[j]        = rd_q[j-1];
      end
      valid_d[0]     = load_valid;
      reg_write_d[0] = load_valid && id_reg_write;
      mem_read_d[0]  = load_valid && id_mem_read;
      rd_d[0]        = load_valid ? id_rd : '0;
      ex_rs_d        = load_valid ? id_rs : '0;
      ex_rs_used_d   = load_valid ? id_rs_used : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      reg_write_q  <= '0;
      mem_read_q   <= '0;
      rd_q         <= '0;
      ex_rs_q      <= '0;
      ex_rs_used_q <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      rd_q         <= rd_d;
      ex_rs_q      <= ex_rs_d;
      ex_rs_used_q <= ex_rs_used_d;
    end
  end

  // A load must never be forwarded from a slot before its data is available.
  always_comb begin
    load_fwd_err = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if ((fwd_sel[i*SEL_W +: SEL_W] != '0) && (32'(fwd_sel[i*SEL_W +: SEL_W]) < LOAD_STAGE) &&
          mem_read_q[fwd_sel[i*SEL_W +: SEL_W]]) begin
        load_fwd_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!load_fwd_err);
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else if (en) begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((|fwd_sel) && (fwd_cnt_q != '1)) fwd_cnt_q <= fwd_cnt_q + 32'd1;
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stat_stall = stall_cnt_q;
  assign stat_fwd   = fwd_cnt_q;
  assign stat_flush = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed bench for fwd_hazard_unit against an instruction-history model.
module tb_fwd_hazard_unit;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned NUM_SRC    = 2;
  localparam int unsigned FWD_DEPTH  = 2;
  localparam int unsigned LOAD_STAGE = 2;
  localparam int unsigned SEL_W      = $clog2(FWD_DEPTH + 1);

  logic                      clk = 1'b0;
  logic                      rst, en, flush, id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [REG_AW-1:0]         id_rd;
  logic                      id_reg_write, id_mem_read;
  logic                      stall, ex_valid;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stat_stall, stat_fwd, stat_flush;
`endif

  fwd_hazard_unit #(
    .REG_AW    (REG_AW),
    .NUM_SRC   (NUM_SRC),
    .FWD_DEPTH (FWD_DEPTH),
    .LOAD_STAGE(LOAD_STAGE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rs_used  (id_rs_used),
    .id_rd       (id_rd),
    .id_reg_write(id_reg_write),
    .id_mem_read (id_mem_read),
    .stall       (stall),
    .fwd_sel     (fwd_sel),
    .ex_valid    (ex_valid)
`ifdef FWD_HAZARD_STATS_EN
    ,
    .stat_stall  (stat_stall),
    .stat_fwd    (stat_fwd),
    .stat_flush  (stat_flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit                             v;
    bit [REG_AW-1:0]                rd;
    bit                             rw;
    bit                             mr;
    bit [NUM_SRC-1:0][REG_AW-1:0]   rs;
    bit [NUM_SRC-1:0]               used;
  } ins_t;

  // hist[0] is the instruction in EX, hist[k] the one k stages later.
  ins_t hist[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit produces(int k, bit [REG_AW-1:0] a);
    if (k >= hist.size()) return 1'b0;
    return hist[k].v && hist[k].rw && hist[k].rd == a && a != 0;
  endfunction

  function automatic int exp_sel(int i);
    if (hist.size() == 0 || !hist[0].v || !hist[0].used[i]) return 0;
    for (int k = 1; k <= int'(FWD_DEPTH); k++)
      if (produces(k, hist[0].rs[i])) return k;
    return 0;
  endfunction

  function automatic bit exp_stall();
    if (!id_valid || flush) return 1'b0;
    for (int j = 0; j <= int'(LOAD_STAGE) - 2; j++)
      for (int i = 0; i < int'(NUM_SRC); i++)
        if (id_rs_used[i] && produces(j, id_rs[i*REG_AW +: REG_AW]) && hist[j].mr) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sel_of(int i);
    return int'(fwd_sel[i*SEL_W +: SEL_W]);
  endfunction

  // Apply one cycle of ID inputs, compare against the model, then advance the model.
  task automatic step(input bit r, input bit e, input bit f, input bit v,
                      input bit [REG_AW-1:0] rs0, input bit [REG_AW-1:0] rs1,
                      input bit [NUM_SRC-1:0] used, input bit [REG_AW-1:0] rd,
                      input bit rw, input bit mr);
    ins_t nxt;
    bit   st;
    @(negedge clk);
    rst = r; en = e; flush = f; id_valid = v;
    id_rs = {rs1, rs0}; id_rs_used = used; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr;
    #1;
    st = exp_stall();
    check_val("stall", 32'(stall), 32'(st));
    check_val("ex_valid", 32'(ex_valid), (hist.size() > 0) ? 32'(hist[0].v) : 0);
    for (int i = 0; i < int'(NUM_SRC); i++) check_val($sformatf("fwd_sel%0d", i), sel_of(i), exp_sel(i));
    if (r) begin
      hist.delete();
    end else if (e) begin
      nxt = '0;
      if (v && !st && !f) begin
        nxt.v = 1'b1; nxt.rd = rd; nxt.rw = rw; nxt.mr = mr;
        nxt.rs = {rs1, rs0}; nxt.used = used;
      end
      hist.push_front(nxt);
      if (hist.size() > int'(FWD_DEPTH) + 1) void'(hist.pop_back());
    end
  endtask

  task automatic nop();
    step(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    nop();
    check_val("rst_ex_valid", 32'(ex_valid), 0);
    check_val("rst_sel", 32'(fwd_sel), 0);

    // add x5,x1,x2 then sub x6,x5,x5
    step(0, 1, 0, 1, 1, 2, 2'b11, 5, 1, 0);
    step(0, 1, 0, 1, 5, 5, 2'b11, 6, 1, 0);
    nop();
    check_val("c1_sel0", sel_of(0), 1);
    check_val("c1_sel1", sel_of(1), 1);

    // rd=7 twice back to back, then a reader of x7
    step(0, 1, 0, 1, 0, 0, 2'b00, 7, 1, 0);
    step(0, 1, 0, 1, 0, 0, 2'b00, 7, 1, 0);
    step(0, 1, 0, 1, 7, 0, 2'b01, 8, 1, 0);
    nop();
    check_val("c2_sel0", sel_of(0), 1);

    // lw x3 then consumer of x3
    do_reset();
    step(0, 1, 0, 1, 0, 0, 2'b00, 3, 1, 1);
    step(0, 1, 0, 1, 3, 0, 2'b01, 4, 1, 0);
    check_val("c3_stall", 32'(stall), 1);
    step(0, 1, 0, 1, 3, 0, 2'b01, 4, 1, 0);
    check_val("c3_stall2", 32'(stall), 0);
    check_val("c3_bubble", 32'(ex_valid), 0);
    nop();
    check_val("c3_sel0", sel_of(0), 2);

    // x0 producer and unused operand
    do_reset();
    step(0, 1, 0, 1, 0, 0, 2'b00, 0, 1, 0);
    step(0, 1, 0, 1, 0, 9, 2'b01, 9, 1, 0);
    step(0, 1, 0, 1, 9, 9, 2'b10, 1, 1, 0);
    nop();
    check_val("c4_sel0_unused", sel_of(0), 0);
    check_val("c4_sel1_used", sel_of(1), 1);

    // flush together with load-use, then hold
    do_reset();
    step(0, 1, 0, 1, 0, 0, 2'b00, 3, 1, 1);
    step(0, 1, 1, 1, 3, 0, 2'b01, 4, 1, 0);
    check_val("c5_flush_stall", 32'(stall), 0);
    step(0, 1, 0, 1, 0, 0, 2'b00, 6, 1, 0);
    check_val("c5_flush_ex", 32'(ex_valid), 0);
    step(0, 1, 0, 1, 6, 0, 2'b01, 2, 1, 0);
    for (int h = 0; h < 3; h++) step(0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
    check_val("c5_hold_sel", sel_of(0), 1);

    // reset mid-operation
    step(0, 1, 0, 1, 2, 2, 2'b11, 2, 1, 1);
    step(1, 1, 0, 1, 2, 2, 2'b11, 2, 1, 1);
    step(0, 0, 0, 1, 2, 2, 2'b11, 2, 1, 0);
    check_val("c6_ex_valid", 32'(ex_valid), 0);
    check_val("c6_sel", 32'(fwd_sel), 0);
    check_val("c6_stall", 32'(stall), 0);
`ifdef FWD_HAZARD_STATS_EN
    check_val("c6_stat_stall", stat_stall, 0);
    check_val("c6_stat_fwd", stat_fwd, 0);
    check_val("c6_stat_flush", stat_flush, 0);
`endif

    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) != 0, REG_AW'($urandom_range(0, 3)),
           REG_AW'($urandom_range(0, 3)), NUM_SRC'($urandom_range(0, 3)),
           REG_AW'($urandom_range(0, 3)), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational EX-stage forwarding selector.
- Keeps its own shadow pipeline of destination-register info from EX back through FWD_DEPTH later stages, fed only by ID-stage decode.
- Per EX source operand, selects the youngest matching producer independently.
- Detects load-use hazards and generates the ID stall, honouring x0, bubbles, flushes and global pipeline holds.

Parameters:
- REG_AW, 5: register address width.
- NUM_SRC, 2: source operands per instruction.
- FWD_DEPTH, 2: forwardable stages after EX (slot 1=MEM, 2=WB, ...); range 1..6.
- LOAD_STAGE, 2: first slot index at which load data is forwardable; range 1..FWD_DEPTH.
- SEL_W, $clog2(FWD_DEPTH+1): width of each select field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  global pipeline advance; 0 holds all state.
- flush  in  1  squash the ID instruction and EX slot.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NUM_SRC*REG_AW  ID source addresses; operand i at [i*REG_AW +: REG_AW].
- id_rs_used  in  NUM_SRC  operand i is actually read.
- id_rd  in  REG_AW  ID destination.
- id_reg_write  in  1  ID writes rd.
- id_mem_read  in  1  ID is a load.
- stall  out  1  hold PC/IF-ID; insert bubble into EX.
- fwd_sel  out  NUM_SRC*SEL_W  per EX operand: 0 = register file, k = slot k.
- ex_valid  out  1  EX slot holds a real instruction.

Behaviour:
- Slot state: slots 0..FWD_DEPTH, slot 0 = EX.
  - Each slot holds {valid, rd, reg_write, mem_read}.
  - Slot 0 additionally holds rs[NUM_SRC] and rs_used[NUM_SRC].
- Reset (rst=1 at a clk edge): all slots invalid, all fields 0. Outputs stall=0, fwd_sel=0, ex_valid=0 from the cycle after the reset edge.
- Producer match: slot j matches address a iff valid & reg_write & rd==a & a!=0.
- Forward select for EX operand i:
  - If slot 0 is invalid or rs_used[i]=0, select 0.
  - Otherwise select the smallest k in 1..FWD_DEPTH whose slot matches rs[i].
  - If nothing matches, select 0.
  - fwd_sel is combinational from registered state.
- Load-use stall:
  - stall=1 iff id_valid & !flush & some slot j, 0 <= j <= LOAD_STAGE-2, is a load (mem_read=1) matching any used id_rs.
  - The condition is combinational.
- Load safety: a load in slot k < LOAD_STAGE is never selected. The stall guarantees this; an assertion checks it.
- Clock edge with en=1:
  - Slots shift: slot j+1 <= slot j, for j = 0..FWD_DEPTH-1.
  - The oldest slot drops out.
  - Slot 0 <= ID instruction, with valid = id_valid & !stall & !flush.
  - When slot 0 loads a bubble, its other fields are cleared.
- Clock edge with en=0: all slots hold. stall and fwd_sel still track inputs and state combinationally.
- Flush with en=1: slot 0 loads a bubble and slot 0 contents still shift into slot 1. Older stages are not flushed.
- Flush and stall together: flush wins and stall=0.
- Consecutive loads: the stall repeats each cycle until no slot ≤ LOAD_STAGE-2 holds a matching load.
- With LOAD_STAGE=1 the stall never asserts.
- Simultaneous matches in several slots: the youngest (lowest index) wins.
- Both operands naming the same register get the same select.
- Latency: a producer entering slot 0 at edge N is forwardable to a consumer in EX at edge N+1 (select 1). With default parameters a load needs exactly one stall cycle.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- When defined, three 32-bit saturating counters are added, each reset to 0 by rst:
  - stall_cnt: cycles with stall=1 & en=1.
  - fwd_cnt: en=1 cycles in which any fwd_sel field is nonzero.
  - flush_cnt: cycles with flush=1 & en=1.
- They are exposed as output ports stat_stall, stat_fwd and stat_flush, each 32 bits.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Case 1, default params. ID: add x5,x1,x2 (rd=5, reg_write=1). Next cycle: sub x6,x5,x5 (both rs=5 used). After the second edge: fwd_sel op0 = op1 = 1, stall=0.
- Case 2, back-to-back producers. Slot 1 holds rd=7, then slot 2 holds rd=7 from an older instruction, and the EX instruction reads x7. Required: select 1, the youngest.
- Case 3, load-use. lw x3 enters EX; ID instruction uses rs1=3.
  - Same cycle: stall=1; slot 0 becomes a bubble at the next edge.
  - Next cycle: stall=0, the consumer enters EX, and fwd_sel op0=2.
- Case 4, x0 and unused operands. Producer rd=0 with consumer rs=0 gives fwd_sel=0. A match on an operand with rs_used=0 gives 0 for that operand.
- Case 5, flush and hold.
  - Flush together with the load-use condition: stall=0 and slot 0 becomes invalid (ex_valid=0 next cycle).
  - en=0 for 3 cycles: state and fwd_sel unchanged.
- Case 6, reset mid-operation. Slots full with matching producers; assert rst for 1 cycle. Required: fwd_sel=0, stall=0 for a matching ID instruction, ex_valid=0. With FWD_HAZARD_STATS_EN defined, all counters read 0.
